// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store sequencer for word-addressed data memory
module mem_access_unit #(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_RMW_READ = 3'd2,
      S_STORE    = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          lane_q;
   logic [1:0]          size_q;
   logic                unsigned_q;
   logic [15:0]         wdata_q;
   logic [31:0]         merge_q;
   logic [31:0]         rdata_q;
   logic                fault_q;
   logic                accept;
   logic                req_fault;

   // Big-endian lane extraction: lane 0 is the most significant byte.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      res = word;
      if (size == 2'b00) begin
         sh  = word >> {~lane, 3'b000};
         res = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end else if (size == 2'b01) begin
         sh  = word >> {~lane[1], 4'b0000};
         res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      return res;
   endfunction

   // Replace the addressed byte or halfword lane of a memory word with store data.
   function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] data,
                                         input logic [1:0] lane, input logic [1:0] size);
      logic [4:0]  sh;
      logic [31:0] mask;
      logic [31:0] ins;
      if (size == 2'b00) begin
         sh   = {~lane, 3'b000};
         mask = 32'h0000_00ff << sh;
         ins  = {24'd0, data[7:0]} << sh;
      end else begin
         sh   = {~lane[1], 4'b0000};
         mask = 32'h0000_ffff << sh;
         ins  = {16'd0, data} << sh;
      end
      return (word & ~mask) | ins;
   endfunction

   assign req_ready = (state_q == S_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign req_fault = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || ((req_addr >> (ADDR_W + 2)) != 32'd0);

   // State register; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_fault)               state_d = S_RESP;
               else if (!req_write)         state_d = S_LOAD;
               else if (req_size == 2'b10)  state_d = S_STORE;
               else                         state_d = S_RMW_READ;
            end
         end
         S_LOAD:     state_d = S_RESP;
         S_RMW_READ: state_d = S_STORE;
         S_STORE:    state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Request capture, load extraction and read-modify-write merge.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         lane_q     <= 2'b00;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         wdata_q    <= 16'd0;
         merge_q    <= 32'd0;
         rdata_q    <= 32'd0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  addr_q     <= req_addr[ADDR_W+1:2];
                  lane_q     <= req_addr[1:0];
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  wdata_q    <= req_wdata[15:0];
                  fault_q    <= req_fault;
                  rdata_q    <= 32'd0;
                  if (req_write && (req_size == 2'b10) && !req_fault)
                     merge_q <= req_wdata;
               end
            end
            S_LOAD:     rdata_q <= extract(mem_read_data, lane_q, size_q, unsigned_q);
            S_RMW_READ: merge_q <= merge(mem_read_data, wdata_q, lane_q, size_q);
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; everything is held at 0 while reset is asserted.
   always_comb begin
      resp_valid     = 1'b0;
      resp_rdata     = 32'd0;
      resp_fault     = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = 32'd0;
      if (!reset) begin
         mem_address    = addr_q;
         mem_write_data = merge_q;
         mem_read       = (state_q == S_LOAD) || (state_q == S_RMW_READ);
         mem_write      = (state_q == S_STORE);
         if (state_q == S_RESP) begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_fault = fault_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_read_data;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_fail   = 0;

   int                lat, nrd, nwr;
   logic [31:0]       rd, wdo;
   logic              flt;
   logic [ADDR_W-1:0] wa;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read (garbage when not enabled), write at rising edge.
   assign mem_read_data = mem_read ? mem[mem_address] : 32'hDEAD_BEEF;
   always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

   // Issue one request from a negedge and monitor it until its response cycle.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
      int n;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; nrd = 0; nwr = 0; wa = '0; wdo = 32'd0;
      while (!resp_valid && lat < 10) begin
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; wa = mem_address; wdo = mem_write_data; end
         @(negedge clk);
         lat++;
      end
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      rd  = resp_rdata;
      flt = resp_fault;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(negedge clk);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      n_checks++; if ({resp_valid, resp_fault, mem_read, mem_write} !== 4'b0000) begin n_fail++; $display("FAIL rst_ctrl: got %b want 0000", {resp_valid, resp_fault, mem_read, mem_write}); end
      n_checks++; if ({resp_rdata, mem_write_data} !== 64'd0 || mem_address !== '0) begin n_fail++; $display("FAIL rst_data: got %h %h %h want 0", resp_rdata, mem_write_data, mem_address); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
   endtask

   task automatic test_word_store_load;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
      n_checks++; if (nwr !== 1 || nrd !== 0) begin n_fail++; $display("FAIL sw_strobes: got wr=%0d rd=%0d want wr=1 rd=0", nwr, nrd); end
      n_checks++; if (wa !== 13'd4 || wdo !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_bus: got addr=%0d data=%h want 4 12345678", wa, wdo); end
      n_checks++; if (flt !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_resp: got fault=%b rdata=%h want 0 0", flt, rd); end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
      n_checks++; if (rd !== 32'h1234_5678 || flt !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h fault=%b want 12345678 0", rd, flt); end
      n_checks++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lw_strobes: got rd=%0d wr=%0d want 1 0", nrd, nwr); end
   endtask

   task automatic test_sub_word_store;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
      n_checks++; if (nrd !== 1 || nwr !== 1) begin n_fail++; $display("FAIL sb_strobes: got rd=%0d wr=%0d want 1 1", nrd, nwr); end
      n_checks++; if (wa !== 13'd4 || wdo !== 32'h11AB_3344) begin n_fail++; $display("FAIL sb_merge: got addr=%0d data=%h want 4 11ab3344", wa, wdo); end
      do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", lat); end
      n_checks++; if (mem[4] !== 32'h11AB_BEEF) begin n_fail++; $display("FAIL sh_merge: got %h want 11abbeef", mem[4]); end
   endtask

   task automatic test_load_extend;
      logic [31:0] addrs [6] = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h23, 32'h20};
      logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
      logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01,
                                 32'hFFFF_80FF, 32'h0000_0001, 32'h0000_80FF};
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01);
      for (int i = 0; i < 6; i++) begin
         do_req(1'b0, sizes[i], unss[i], addrs[i], 32'd0);
         n_checks++; if (rd !== exps[i] || lat !== 2) begin n_fail++; $display("FAIL load_ext[%0d]: got %h lat=%0d want %h lat=2", i, rd, lat, exps[i]); end
      end
   endtask

   task automatic test_faults;
      logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  szs [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
      logic [31:0] as  [4] = '{32'h13, 32'h12, 32'h10, 32'h8000};
      for (int i = 0; i < 4; i++) begin
         do_req(ws[i], szs[i], 1'b0, as[i], 32'hFFFF_FFFF);
         n_checks++; if (flt !== 1'b1 || lat !== 1 || rd !== 32'd0) begin n_fail++; $display("FAIL fault[%0d]: got fault=%b lat=%0d rdata=%h want 1 1 0", i, flt, lat, rd); end
         n_checks++; if (nrd !== 0 || nwr !== 0) begin n_fail++; $display("FAIL fault_mem[%0d]: got rd=%0d wr=%0d want 0 0", i, nrd, nwr); end
      end
      n_checks++; if (mem[4] !== 32'h11AB_BEEF || mem[0] !== 32'd0) begin n_fail++; $display("FAIL fault_contents: got %h %h want 11abbeef 0", mem[4], mem[0]); end
   endtask

   task automatic test_reset_midflight;
      int n, wr_seen, rv_seen;
      // Reset during the read phase of a halfword store.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_addr = 32'h20; req_wdata = 32'h5555;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      wr_seen = 0; rv_seen = 0;
      n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmw_read_phase: got mem_read=%b want 1", mem_read); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if ({req_ready, resp_valid, mem_read, mem_write, resp_fault} !== 5'd0 || mem_address !== '0 || mem_write_data !== 32'd0 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_outputs: got %b %h %h %h want all 0", {req_ready, resp_valid, mem_read, mem_write, resp_fault}, mem_address, mem_write_data, resp_rdata); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
      for (int c = 0; c < 5; c++) begin
         if (mem_write) wr_seen++;
         if (resp_valid) rv_seen++;
         @(negedge clk);
      end
      n_checks++; if (wr_seen !== 0 || rv_seen !== 0) begin n_fail++; $display("FAIL reset_dropped: got wr=%0d resp=%0d want 0 0", wr_seen, rv_seen); end
      n_checks++; if (mem[8] !== 32'h80FF_7F01) begin n_fail++; $display("FAIL reset_word: got %h want 80ff7f01", mem[8]); end
      // Reset while a word store is in its write cycle.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL store_reset_write: got %b want 0", mem_write); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (mem[12] === 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_reset_word: got %h want untouched", mem[12]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exps [4] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
      int idx, nresp, last;
      logic pending;
      for (int i = 0; i < 4; i++) do_req(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4*i), exps[i]);
      idx = 0; nresp = 0; last = 0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
      pending = req_valid && req_ready;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (pending) begin
            idx++;
            if (idx < 4) req_addr = 32'h40 + 32'(4*idx);
            else req_valid = 1'b0;
         end
         if (resp_valid) begin
            if (nresp < 4) begin
               n_checks++; if (resp_rdata !== exps[nresp]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", nresp, resp_rdata, exps[nresp]); end
            end
            if (nresp > 0) begin
               n_checks++; if (c - last !== 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", nresp, c - last); end
            end
            last = c;
            nresp++;
         end
         pending = req_valid && req_ready;
      end
      n_checks++; if (nresp !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", nresp); end
   endtask

   initial begin
      test_reset;
      test_word_store_load;
      test_sub_word_store;
      test_load_extend;
      test_faults;
      test_reset_midflight;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the MEM pipeline stage and the word-addressed `data_memory`. Accepts one byte, halfword or word request per handshake from the CPU using a byte address. It drives the memory's `address`/`write_data`/`memread`/`memwrite` pins and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or a fault for misaligned or out-of-range accesses.

## Interface
Parameters:
- `ADDR_W`, 13, memory word-address width; capacity 2^ADDR_W words, byte range 0 .. 4·2^ADDR_W−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE and not in reset.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: zero-extend (lbu/lhu) when 1, sign-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse for every accepted request.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  qualifies `resp_valid`; misaligned, illegal size or out of range.
- `mem_address`  out  ADDR_W  word index = `req_addr[ADDR_W+1:2]`.
- `mem_write_data`  out  32  merged word.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable (sampled by memory at rising edge).
- `mem_read_data`  in  32  combinational read data from memory.

## Operation
- Byte order is big-endian. Byte lane `a[1:0]` = 0 occupies bits [31:24], lane 3 occupies [7:0]. Halfword at `a[1]` = 0 occupies [31:16].
- Accept happens when `req_valid && req_ready`. Address, size, write, unsigned flag and data are registered.
- Faults are checked at accept:
  - halfword with `a[0]` = 1;
  - word with `a[1:0]` ≠ 0;
  - size 11;
  - `a[31:ADDR_W+2]` ≠ 0.
- On a fault, the unit goes to RESP with `resp_fault` = 1. It makes no memory access: `mem_read` = `mem_write` = 0 throughout.
- FSM states: IDLE, LOAD, RMW_READ, STORE, RESP.
  - IDLE → LOAD on an accepted load.
  - IDLE → STORE on an accepted word store.
  - IDLE → RMW_READ on an accepted byte or halfword store.
  - IDLE → RESP on a fault.
  - LOAD → RESP. In LOAD, `mem_read` = 1. At the edge, the selected lane is extracted and extended into `resp_rdata`.
  - RMW_READ → STORE. In RMW_READ, `mem_read` = 1. `mem_read_data` is captured into the merge register.
  - STORE → RESP. In STORE, `mem_write` = 1. `mem_write_data` is the merge register with the addressed lane replaced by `req_wdata` (the whole word for word stores).
  - RESP → IDLE. `resp_valid` = 1 for exactly this cycle.
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 in IDLE and RESP.
- `mem_address` and `mem_write_data` hold their registered values between accesses.
- The memory's `read_data` holds stale values when `memread` is low. It is sampled only in LOAD and RMW_READ.

## Timing
- Reset values: state IDLE, `req_ready` 0 during the reset cycle, and every other output 0.
- Reset asserted in any state returns the FSM to IDLE at that edge, and the in-flight request is dropped.
  - No `resp_valid` is issued for a dropped request.
  - If reset is high during STORE, `mem_write` is forced 0 in that cycle so no partial write occurs.
- `req_ready` is combinational from state: high in IDLE only. A request arriving in RESP waits one cycle.
- Latency, counted from the accept edge to the `resp_valid` cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - fault: 1 cycle.
- Back-to-back throughput: one load per 3 cycles (IDLE, LOAD, RESP).
- `req_*` inputs are ignored whenever `req_ready` = 0.

## Test plan
- Word store `0x12345678` at byte 0x10, then `lw` at 0x10:
  - `mem_write` is high for exactly 1 cycle with `mem_address` = 4;
  - `resp_rdata` = `0x12345678`, `resp_fault` = 0, with latency 2 for each request.
- Memory word 4 = `0x11223344`, then `sb 0xAB` at byte 0x11:
  - `mem_read` is high 1 cycle, then `mem_write` is high 1 cycle with `mem_write_data` = `0x11AB3344`;
  - `resp_valid` arrives 3 cycles after accept.
- Word = `0x80FF7F01`:
  - `lb` at lane 0 gives `0xFFFFFF80`;
  - `lbu` at lane 0 gives `0x00000080`;
  - `lh` at lane 2 gives `0x00007F01`;
  - `lh` at lane 0 gives `0xFFFF80FF`.
- Faults:
  - `lh` at 0x13, `sw` at 0x12, size 11, and address `0x00008000` each give `resp_fault` = 1 one cycle after accept;
  - `mem_read` and `mem_write` stay 0;
  - memory contents are unchanged.
- Reset:
  - assert `reset` during RMW_READ of an `sh`: no `mem_write` ever occurs, no `resp_valid` is issued, the target word is unchanged, and `req_ready` = 1 the cycle after reset deasserts;
  - all outputs are 0 while `reset` is held.
- Hold `req_valid` high with 4 queued loads: each is accepted only when `req_ready` = 1, 4 `resp_valid` pulses occur at 3-cycle spacing, and data matches in order.
